// File: rtl/acc_pkg.sv
// acc_pkg: shared opcode, mode, ALU code and state definitions for the accumulator control unit
package acc_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_LOAD = 3'b001, OP_STORE = 3'b010, OP_SUB = 3'b011,
    OP_JMP = 3'b100, OP_JZ = 3'b101, OP_RSV = 3'b110, OP_HALT = 3'b111
  } opcode_t;
  typedef enum logic [1:0] {MODE_IMM = 2'b00, MODE_DIR = 2'b01} mode_t;
  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000, ALU_PASS_B = 3'b001, ALU_ADD = 3'b011, ALU_SUB = 3'b100
  } alu_t;
  typedef enum logic [3:0] {
    FETCH_PC, FETCH_RD, FETCH_IR, DECODE, EX_ADDR, EX_RD, EX_ALU, EX_STD, EX_WR, EX_JMP, HALT
  } state_t;
  function automatic logic op_legal(input logic [2:0] op, input logic [1:0] mode);
    case (op)
      OP_ADD, OP_SUB, OP_LOAD, OP_HALT: op_legal = !mode[1];
      OP_STORE: op_legal = mode == MODE_DIR;
      OP_JMP, OP_JZ: op_legal = mode == MODE_IMM;
      default: op_legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/acc_mem_wait.sv
// acc_mem_wait: memory ready wait counter with timeout detection
module acc_mem_wait #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ready,
  output logic timeout
);
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  logic [WAIT_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (start) cnt <= '0;
    else if (!ready) cnt <= cnt + 1'b1;
  assign timeout = !start && !ready && cnt == WAIT_W'(WAIT_MAX - 1);
endmodule

// File: rtl/acc_control_unit.sv
// acc_control_unit: handshake-driven fetch/decode/execute sequencer for the accumulator datapath
module acc_control_unit
  import acc_pkg::*;
#(
  parameter int INST_W = 18,
  parameter int OP_W = 3,
  parameter int MODE_W = 2,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst_in,
  input  logic              mem_ready,
  input  logic              ac_zero,
  output logic              rMAR,
  output logic              wMAR,
  output logic              rMem,
  output logic              wMem,
  output logic              rMDR,
  output logic              wMDRmem,
  output logic              wMDRbus,
  output logic              rPC,
  output logic              wPC,
  output logic              incPC,
  output logic              rIR,
  output logic              wIR,
  output logic              rAC,
  output logic              wAC,
  output logic [2:0]        cALU,
  output logic              eALU,
  output logic              halted,
  output logic              illegal_op,
  output logic              bus_error
);
  localparam int ADDR_W = INST_W - OP_W - MODE_W;
  state_t state, nxt;
  logic [OP_W+MODE_W-1:0] ctl;
  logic [OP_W-1:0] op;
  logic [MODE_W-1:0] mode;
  logic legal, imm, idle, timeout, unused;
  assign unused = ^inst_in[ADDR_W-1:0];
  assign op = ctl[OP_W+MODE_W-1 -: OP_W];
  assign mode = ctl[MODE_W-1:0];
  assign legal = op_legal(op, mode);
  assign imm = mode == MODE_IMM;
  assign idle = !(state == FETCH_RD || state == EX_RD || state == EX_WR);
  acc_mem_wait #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk(clk), .reset(reset), .start(idle), .ready(mem_ready), .timeout(timeout)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= FETCH_PC;
      ctl <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= nxt;
      if (state == FETCH_IR) ctl <= inst_in[INST_W-1 -: OP_W+MODE_W];
      if (timeout) bus_error <= 1'b1;
    end
  always_comb begin
    nxt = state;
    case (state)
      FETCH_PC: nxt = FETCH_RD;
      FETCH_RD: nxt = timeout ? HALT : mem_ready ? FETCH_IR : FETCH_RD;
      FETCH_IR: nxt = DECODE;
      DECODE: nxt = !legal ? FETCH_PC : op == OP_HALT ? HALT : op == OP_JMP ? EX_JMP :
                    op == OP_JZ ? (ac_zero ? EX_JMP : FETCH_PC) : imm ? EX_ALU : EX_ADDR;
      EX_ADDR: nxt = op == OP_STORE ? EX_STD : EX_RD;
      EX_RD: nxt = timeout ? HALT : mem_ready ? EX_ALU : EX_RD;
      EX_STD: nxt = EX_WR;
      EX_WR: nxt = timeout ? HALT : mem_ready ? FETCH_PC : EX_WR;
      HALT: nxt = HALT;
      default: nxt = FETCH_PC;
    endcase
  end
  always_comb begin
    {rMAR, wMAR, rMem, wMem, rMDR, wMDRmem, wMDRbus, rPC, wPC, incPC, rIR, wIR, rAC, wAC, eALU} = '0;
    {halted, illegal_op} = '0;
    cALU = ALU_PASS_A;
    if (!reset)
      case (state)
        FETCH_PC: {rPC, eALU, wMAR} = '1;
        FETCH_RD, EX_RD: {rMAR, rMem, wMDRmem} = {2'b11, mem_ready};
        FETCH_IR: begin
          {rMDR, eALU, wIR, incPC} = '1;
          cALU = ALU_PASS_B;
        end
        DECODE: illegal_op = !legal;
        EX_ADDR: {rIR, eALU, wMAR} = '1;
        EX_ALU: begin
          {rMDR, rIR, eALU, wAC} = {!imm, imm, 2'b11};
          rAC = op == OP_ADD || op == OP_SUB;
          cALU = op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : imm ? ALU_PASS_A : ALU_PASS_B;
        end
        EX_STD: {rAC, eALU, wMDRbus} = '1;
        EX_WR: {rMAR, wMem} = '1;
        EX_JMP: {rIR, eALU, wPC} = '1;
        HALT: halted = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: tb/tb_acc_control_unit.sv
// tb_acc_control_unit: directed per-cycle strobe checks of the accumulator control unit
module tb_acc_control_unit;
  localparam logic [20:0] K_RMAR = 21'd1 << 20, K_WMAR = 21'd1 << 19, K_RMEM = 21'd1 << 18,
    K_WMEM = 21'd1 << 17, K_RMDR = 21'd1 << 16, K_WMDRM = 21'd1 << 15, K_WMDRB = 21'd1 << 14,
    K_RPC = 21'd1 << 13, K_WPC = 21'd1 << 12, K_INCPC = 21'd1 << 11, K_RIR = 21'd1 << 10,
    K_WIR = 21'd1 << 9, K_RAC = 21'd1 << 8, K_WAC = 21'd1 << 7, K_EALU = 21'd1 << 6,
    K_CPB = 21'd1 << 3, K_CADD = 21'd3 << 3, K_HALT = 21'd1 << 2, K_ILL = 21'd1 << 1, K_BERR = 21'd1;
  localparam logic [20:0] FPC = K_RPC | K_EALU | K_WMAR, FRD = K_RMAR | K_RMEM,
    FRDM = FRD | K_WMDRM, FIR = K_RMDR | K_EALU | K_CPB | K_WIR | K_INCPC,
    EXA = K_RIR | K_EALU | K_WMAR, ADDD = K_RMDR | K_RAC | K_EALU | K_WAC | K_CADD,
    LDI = K_RIR | K_EALU | K_WAC, STD = K_RAC | K_EALU | K_WMDRB, WR = K_RMAR | K_WMEM,
    JMP = K_RIR | K_EALU | K_WPC, HLT = K_HALT, ILL = K_ILL, DEC = 21'd0;
  logic clk = 0, reset = 1, rst4 = 1, mem_ready = 1, mr4 = 0, ac_zero = 0;
  logic [17:0] inst_in = '0;
  int checks = 0, failures = 0;
  logic rMAR, wMAR, rMem, wMem, rMDR, wMDRmem, wMDRbus, rPC, wPC, incPC, rIR, wIR, rAC, wAC, eALU;
  logic halted, illegal_op, bus_error;
  logic [2:0] cALU;
  logic rMAR4, wMAR4, rMem4, wMem4, rMDR4, wMDRmem4, wMDRbus4, rPC4, wPC4, incPC4, rIR4, wIR4;
  logic rAC4, wAC4, eALU4, halted4, illegal_op4, bus_error4;
  logic [2:0] cALU4;
  logic [20:0] outv, outv4;
  always #5 clk = ~clk;
  assign outv = {rMAR, wMAR, rMem, wMem, rMDR, wMDRmem, wMDRbus, rPC, wPC, incPC, rIR, wIR, rAC,
                 wAC, eALU, cALU, halted, illegal_op, bus_error};
  assign outv4 = {rMAR4, wMAR4, rMem4, wMem4, rMDR4, wMDRmem4, wMDRbus4, rPC4, wPC4, incPC4, rIR4,
                  wIR4, rAC4, wAC4, eALU4, cALU4, halted4, illegal_op4, bus_error4};
  acc_control_unit dut (
    .clk(clk), .reset(reset), .inst_in(inst_in), .mem_ready(mem_ready), .ac_zero(ac_zero),
    .rMAR(rMAR), .wMAR(wMAR), .rMem(rMem), .wMem(wMem), .rMDR(rMDR), .wMDRmem(wMDRmem),
    .wMDRbus(wMDRbus), .rPC(rPC), .wPC(wPC), .incPC(incPC), .rIR(rIR), .wIR(wIR), .rAC(rAC),
    .wAC(wAC), .cALU(cALU), .eALU(eALU), .halted(halted), .illegal_op(illegal_op),
    .bus_error(bus_error)
  );
  acc_control_unit #(.WAIT_MAX(4)) dut4 (
    .clk(clk), .reset(rst4), .inst_in(inst_in), .mem_ready(mr4), .ac_zero(ac_zero),
    .rMAR(rMAR4), .wMAR(wMAR4), .rMem(rMem4), .wMem(wMem4), .rMDR(rMDR4), .wMDRmem(wMDRmem4),
    .wMDRbus(wMDRbus4), .rPC(rPC4), .wPC(wPC4), .incPC(incPC4), .rIR(rIR4), .wIR(wIR4),
    .rAC(rAC4), .wAC(wAC4), .cALU(cALU4), .eALU(eALU4), .halted(halted4),
    .illegal_op(illegal_op4), .bus_error(bus_error4)
  );
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outv !== 21'd0) begin failures++; $display("FAIL reset_held got=%h exp=%h", outv, 21'd0); end
    reset = 0;
    #1;
    checks++;
    if (outv !== FPC) begin failures++; $display("FAIL reset_release got=%h exp=%h", outv, FPC); end
  endtask
  task automatic test_add_direct();
    logic [20:0] e [8];
    e = '{FPC, FRDM, FIR, DEC, EXA, FRDM, ADDD, FPC};
    inst_in = 18'b000_01_0000000000101;
    mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL add_dir cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 7) begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_load_imm();
    logic [20:0] e [6];
    e = '{FPC, FRDM, FIR, DEC, LDI, FPC};
    inst_in = 18'b001_00_0000000101010;
    mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL load_imm cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 5) begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_store_wait();
    logic [20:0] e [11];
    logic r [11];
    e = '{FPC, FRDM, FIR, DEC, EXA, STD, WR, WR, WR, WR, FPC};
    r = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    inst_in = 18'b010_01_0000000000111;
    for (int i = 0; i < 11; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL store_wait cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 10) begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_jz();
    logic [20:0] e [6];
    e = '{FPC, FRDM, FIR, DEC, JMP, FPC};
    inst_in = 18'b101_00_0000000001001;
    mem_ready = 1;
    ac_zero = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL jz_taken cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 5) begin @(posedge clk); #1; end
    end
    ac_zero = 0;
    e = '{FPC, FRDM, FIR, DEC, FPC, FRDM};
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL jz_not_taken cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_illegal();
    logic [20:0] e [5];
    logic [17:0] insts [2];
    e = '{FPC, FRDM, FIR, ILL, FPC};
    insts = '{18'b110_00_0000000000001, 18'b000_10_0000000000001};
    mem_ready = 1;
    for (int k = 0; k < 2; k++) begin
      inst_in = insts[k];
      for (int i = 0; i < 5; i++) begin
        #1;
        checks++;
        if (outv !== e[i]) begin failures++; $display("FAIL illegal%0d cycle=%0d got=%h exp=%h", k, i, outv, e[i]); end
        if (i < 4) begin @(posedge clk); #1; end
      end
    end
  endtask
  task automatic test_halt();
    logic [20:0] e [6];
    e = '{FPC, FRDM, FIR, DEC, HLT, HLT};
    inst_in = 18'b111_00_0000000000000;
    mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL halt cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 5) begin @(posedge clk); #1; end
    end
    reset = 1;
    #1;
    checks++;
    if (outv !== 21'd0) begin failures++; $display("FAIL halt_reset got=%h exp=%h", outv, 21'd0); end
    reset = 0;
    #1;
    checks++;
    if (outv !== FPC) begin failures++; $display("FAIL halt_restart got=%h exp=%h", outv, FPC); end
  endtask
  task automatic test_reset_mid_access();
    logic [20:0] e [6];
    logic r [6];
    e = '{FPC, FRDM, FIR, DEC, EXA, FRD};
    r = '{1, 1, 1, 1, 1, 0};
    inst_in = 18'b001_01_0000000000011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = r[i];
      #1;
      checks++;
      if (outv !== e[i]) begin failures++; $display("FAIL reset_mid cycle=%0d got=%h exp=%h", i, outv, e[i]); end
      if (i < 5) begin @(posedge clk); #1; end
    end
    reset = 1;
    #1;
    checks++;
    if (outv !== 21'd0) begin failures++; $display("FAIL reset_mid_drop got=%h exp=%h", outv, 21'd0); end
    #1;
    reset = 0;
    mem_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (outv !== FRDM) begin failures++; $display("FAIL reset_mid_refetch got=%h exp=%h", outv, FRDM); end
  endtask
  task automatic test_timeout();
    logic [20:0] e [7];
    logic r [7];
    #1;
    checks++;
    if (outv4 !== 21'd0) begin failures++; $display("FAIL to_reset got=%h exp=%h", outv4, 21'd0); end
    rst4 = 0;
    mr4 = 0;
    e = '{FPC, FRD, FRD, FRD, FRD, HLT | K_BERR, HLT | K_BERR};
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if (outv4 !== e[i]) begin failures++; $display("FAIL timeout cycle=%0d got=%h exp=%h", i, outv4, e[i]); end
      if (i < 6) begin @(posedge clk); #1; end
    end
    rst4 = 1;
    #1;
    checks++;
    if (outv4 !== 21'd0) begin failures++; $display("FAIL timeout_reset got=%h exp=%h", outv4, 21'd0); end
    rst4 = 0;
    e = '{FPC, FRD, FRD, FRD, FRDM, FIR, DEC};
    r = '{1, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      mr4 = r[i];
      #1;
      checks++;
      if (outv4 !== e[i]) begin failures++; $display("FAIL ready_wins cycle=%0d got=%h exp=%h", i, outv4, e[i]); end
      if (i < 5) begin @(posedge clk); #1; end
    end
  endtask
  initial begin
    test_reset();
    test_add_direct();
    test_load_imm();
    test_store_wait();
    test_jz();
    test_illegal();
    test_halt();
    test_reset_mid_access();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
